// File: rtl/pr_bridge_n_pkg.sv
// Shared address map constants, ICTL register indices and decode helpers for the PR bridge.
package pr_bridge_n_pkg;

   localparam logic [63:0]  DEV_BASE_DEF  = {32'h0000_7f10, 32'h0000_7f00};
   localparam logic [31:0]  ICTL_BASE_DEF = 32'h0000_7f20;
   localparam int unsigned  ICTL_BYTES    = 12;
   localparam int unsigned  MAX_DEV       = 5;

   // Word index of a register inside the interrupt-controller window.
   typedef enum logic [1:0] {
      REG_PENDING = 2'd0,
      REG_MASK    = 2'd1,
      REG_ERR     = 2'd2
   } ictl_reg_e;

   // Extra top bit keeps windows near the top of the address space from wrapping.
   function automatic logic in_window(input logic [31:0] wa, input logic [31:0] base,
                                      input int unsigned bytes);
      logic [32:0] lo;
      logic [32:0] hi;
      lo = {1'b0, base};
      hi = lo + 33'(bytes);
      return ({1'b0, wa} >= lo) && ({1'b0, wa} < hi);
   endfunction

   function automatic bit spans_overlap(input logic [31:0] base_a, input int unsigned bytes_a,
                                        input logic [31:0] base_b, input int unsigned bytes_b);
      logic [32:0] a_lo;
      logic [32:0] b_lo;
      a_lo = {1'b0, base_a};
      b_lo = {1'b0, base_b};
      return (a_lo < b_lo + 33'(bytes_b)) && (b_lo < a_lo + 33'(bytes_a));
   endfunction

endpackage

// File: rtl/pr_bridge_n_irq_ctrl.sv
// Interrupt controller: source synchroniser, level/edge pending logic, mask register and
// registered hwint outputs towards CP0.
module pr_irq_ctrl
   import pr_bridge_n_pkg::*;
#(
   parameter int              N_SRC    = 3,
   parameter logic [N_SRC-1:0] IRQ_EDGE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   input  logic             w1c,
   input  logic             mask_we,
   input  logic             mask_be,
   input  logic [N_SRC-1:0] wd,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask,
   output logic [5:0]       hwint
);

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] src_qq;
   logic [N_SRC-1:0] edge_q;
   logic [N_SRC-1:0] edge_nxt;
   logic [N_SRC-1:0] pend_nxt;
   logic [N_SRC-1:0] mask_nxt;
   logic [N_SRC-1:0] hw_q;
   logic [N_SRC-1:0] set;
   logic [N_SRC-1:0] clr;

   // A new edge in the same cycle as a W1C keeps the bit set.
   always_comb begin
      set      = src_q & ~src_qq;
      clr      = w1c ? wd : '0;
      edge_nxt = ((edge_q & ~clr) | set) & IRQ_EDGE;
      for (int k = 0; k < N_SRC; k++) begin
         pend_nxt[k] = IRQ_EDGE[k] ? edge_nxt[k] : src_q[k];
         pending[k]  = IRQ_EDGE[k] ? edge_q[k]   : src_q[k];
      end
      mask_nxt = (mask_we && mask_be) ? wd : mask;
      hwint    = '0;
      hwint[N_SRC-1:0] = hw_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q  <= '0;
         src_qq <= '0;
         edge_q <= '0;
         mask   <= '1;
         hw_q   <= '0;
      end else begin
         src_q  <= src;
         src_qq <= src_q;
         edge_q <= edge_nxt;
         mask   <= mask_nxt;
         hw_q   <= pend_nxt & mask_nxt;
      end
   end

endmodule

// File: rtl/pr_bridge_n.sv
// PR peripheral-port bridge: decodes CPU addresses onto N_DEV device windows plus the
// interrupt-controller registers, forwards writes and returns registered read data.
module pr_bridge_n
   import pr_bridge_n_pkg::*;
#(
   parameter int                  N_DEV     = 2,
   parameter logic [32*N_DEV-1:0] DEV_BASE  = DEV_BASE_DEF,
   parameter int                  DEV_WORDS = 4,
   parameter logic [31:0]         ICTL_BASE = ICTL_BASE_DEF,
   parameter logic [N_DEV:0]      IRQ_EDGE  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pr_a,
   input  logic                  pr_we,
   input  logic                  pr_re,
   input  logic [3:0]            pr_be,
   input  logic [31:0]           pr_wd,
   output logic [31:0]           pr_rd,
   output logic                  pr_rvalid,
   output logic [31:0]           dev_a,
   output logic [N_DEV-1:0]      dev_we,
   output logic [3:0]            dev_be,
   output logic [31:0]           dev_wd,
   input  logic [32*N_DEV-1:0]   dev_rd,
   input  logic [N_DEV-1:0]      dev_irq,
   input  logic                  ext_int,
   output logic [5:0]            hwint,
   output logic                  bus_err
);

   localparam int unsigned DEV_BYTES = 4 * DEV_WORDS;

   function automatic bit windows_clash();
      bit clash;
      clash = 1'b0;
      for (int i = 0; i < N_DEV; i++) begin
         if (spans_overlap(DEV_BASE[32*i +: 32], DEV_BYTES, ICTL_BASE, ICTL_BYTES)) clash = 1'b1;
         for (int j = i + 1; j < N_DEV; j++) begin
            if (spans_overlap(DEV_BASE[32*i +: 32], DEV_BYTES, DEV_BASE[32*j +: 32], DEV_BYTES))
               clash = 1'b1;
         end
      end
      return clash;
   endfunction

   localparam bit WINDOW_CLASH = windows_clash();

   if (WINDOW_CLASH) begin : g_window_clash
      $error("pr_bridge_n: address windows overlap");
   end
   if (N_DEV < 1 || N_DEV > MAX_DEV) begin : g_bad_ndev
      $error("pr_bridge_n: N_DEV out of range");
   end

   logic [31:0]      wa;
   logic [N_DEV-1:0] sel;
   logic             dev_hit;
   logic             ictl_hit;
   logic [31:0]      dev_base_sel;
   logic [31:0]      dev_rd_sel;
   logic [31:0]      ictl_off;
   ictl_reg_e        ictl_idx;
   logic             ictl_wr;
   logic             unmapped;
   logic             err_clr;
   logic [31:0]      rd_nxt;
   logic [N_DEV:0]   pending;
   logic [N_DEV:0]   mask;
   logic             unused_ok;

   assign wa = {pr_a[31:2], 2'b00};

   // Scan from index 0 upward so the lowest device wins if windows ever overlap.
   always_comb begin
      sel          = '0;
      dev_hit      = 1'b0;
      dev_base_sel = '0;
      dev_rd_sel   = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (!dev_hit && in_window(wa, DEV_BASE[32*i +: 32], DEV_BYTES)) begin
            sel[i]       = 1'b1;
            dev_hit      = 1'b1;
            dev_base_sel = DEV_BASE[32*i +: 32];
            dev_rd_sel   = dev_rd[32*i +: 32];
         end
      end
      ictl_hit = !dev_hit && in_window(wa, ICTL_BASE, ICTL_BYTES);
   end

   assign ictl_off = wa - ICTL_BASE;
   assign ictl_idx = ictl_reg_e'(ictl_off[3:2]);
   assign ictl_wr  = pr_we && ictl_hit;
   assign err_clr  = ictl_wr && (ictl_idx == REG_ERR);
   assign unmapped = (pr_we || pr_re) && !dev_hit && !ictl_hit;

   assign dev_a  = wa - dev_base_sel;
   assign dev_we = pr_we ? sel : '0;
   assign dev_be = pr_be;
   assign dev_wd = pr_wd;

   always_comb begin
      rd_nxt = '0;
      if (dev_hit) begin
         rd_nxt = dev_rd_sel;
      end else if (ictl_hit) begin
         case (ictl_idx)
            REG_PENDING: rd_nxt[N_DEV:0] = pending;
            REG_MASK:    rd_nxt[N_DEV:0] = mask;
            REG_ERR:     rd_nxt[0]       = bus_err;
            default:     rd_nxt          = '0;
         endcase
      end
   end

   // A fresh unmapped access outranks a same-cycle ERR clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pr_rd     <= '0;
         pr_rvalid <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         pr_rvalid <= pr_re;
         if (pr_re) pr_rd <= rd_nxt;
         if (unmapped)     bus_err <= 1'b1;
         else if (err_clr) bus_err <= 1'b0;
      end
   end

   pr_irq_ctrl #(
      .N_SRC    (N_DEV + 1),
      .IRQ_EDGE (IRQ_EDGE)
   ) u_irq (
      .clk     (clk),
      .reset   (reset),
      .src     ({ext_int, dev_irq}),
      .w1c     (ictl_wr && (ictl_idx == REG_PENDING)),
      .mask_we (ictl_wr && (ictl_idx == REG_MASK)),
      .mask_be (pr_be[0]),
      .wd      (pr_wd[N_DEV:0]),
      .pending (pending),
      .mask    (mask),
      .hwint   (hwint)
   );

   assign unused_ok = ^{pr_a[1:0], ictl_off[31:4], ictl_off[1:0]};

endmodule

// File: tb/tb_pr_bridge_n.sv
// Directed bench for pr_bridge_n: table of single bus accesses plus hand-written
// sequences for bus errors, interrupt latency/W1C/mask and reset during a read.
module tb_pr_bridge_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pr_a;
   logic        pr_we;
   logic        pr_re;
   logic [3:0]  pr_be;
   logic [31:0] pr_wd;
   logic [31:0] pr_rd;
   logic        pr_rvalid;
   logic [31:0] dev_a;
   logic [1:0]  dev_we;
   logic [3:0]  dev_be;
   logic [31:0] dev_wd;
   logic [63:0] dev_rd;
   logic [1:0]  dev_irq;
   logic        ext_int;
   logic [5:0]  hwint;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pr_bridge_n #(.IRQ_EDGE(3'b001)) dut (
      .clk       (clk),
      .reset     (reset),
      .pr_a      (pr_a),
      .pr_we     (pr_we),
      .pr_re     (pr_re),
      .pr_be     (pr_be),
      .pr_wd     (pr_wd),
      .pr_rd     (pr_rd),
      .pr_rvalid (pr_rvalid),
      .dev_a     (dev_a),
      .dev_we    (dev_we),
      .dev_be    (dev_be),
      .dev_wd    (dev_wd),
      .dev_rd    (dev_rd),
      .dev_irq   (dev_irq),
      .ext_int   (ext_int),
      .hwint     (hwint),
      .bus_err   (bus_err)
   );

   typedef struct {
      logic [31:0] a;
      logic        we;
      logic        re;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [1:0]  exp_we;
      logic        chk_a;
      logic [31:0] exp_a;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic re,
                        input logic [3:0] be, input logic [31:0] wd);
      pr_a  = a;
      pr_we = we;
      pr_re = re;
      pr_be = be;
      pr_wd = wd;
   endtask

   task automatic idle();
      pr_we = 1'b0;
      pr_re = 1'b0;
   endtask

   // One access, one edge, strobes dropped afterwards.
   task automatic access(input logic [31:0] a, input logic we, input logic re,
                         input logic [3:0] be, input logic [31:0] wd);
      drive(a, we, re, be, wd);
      tick();
      idle();
   endtask

   initial begin
      vecs[0]  = '{32'h7f24, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b0, 32'h0, 32'h7};
      vecs[1]  = '{32'h7f04, 1'b1, 1'b0, 4'hf, 32'h5,  2'b01, 1'b1, 32'h4, 32'h0};
      vecs[2]  = '{32'h7f18, 1'b1, 1'b0, 4'hf, 32'h9,  2'b10, 1'b1, 32'h8, 32'h0};
      vecs[3]  = '{32'h7f14, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b1, 32'h4, 32'h0000_a5a5};
      vecs[4]  = '{32'h7f00, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b1, 32'h0, 32'h1234_5678};
      vecs[5]  = '{32'h7f0c, 1'b1, 1'b0, 4'h3, 32'hbeef, 2'b01, 1'b1, 32'hc, 32'h0};
      vecs[6]  = '{32'h7f10, 1'b1, 1'b0, 4'h8, 32'h77, 2'b10, 1'b1, 32'h0, 32'h0};
      vecs[7]  = '{32'h7f1f, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b1, 32'hc, 32'h0000_a5a5};
      vecs[8]  = '{32'h7f20, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b0, 32'h0, 32'h0};
      vecs[9]  = '{32'h7f28, 1'b0, 1'b1, 4'h0, 32'h0,  2'b00, 1'b0, 32'h0, 32'h0};
      vecs[10] = '{32'h7f0e, 1'b1, 1'b0, 4'h1, 32'h3c, 2'b01, 1'b1, 32'hc, 32'h0};

      reset   = 1'b1;
      dev_rd  = {32'h0000_a5a5, 32'h1234_5678};
      dev_irq = 2'b00;
      ext_int = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
      repeat (3) tick();
      chk("reset pr_rd", pr_rd, 32'h0);
      chk("reset pr_rvalid", {31'h0, pr_rvalid}, 32'h0);
      chk("reset hwint", {26'h0, hwint}, 32'h0);
      chk("reset bus_err", {31'h0, bus_err}, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].a, vecs[i].we, vecs[i].re, vecs[i].be, vecs[i].wd);
         #1;
         chk($sformatf("v%0d dev_we", i), {30'h0, dev_we}, {30'h0, vecs[i].exp_we});
         if (vecs[i].chk_a) chk($sformatf("v%0d dev_a", i), dev_a, vecs[i].exp_a);
         chk($sformatf("v%0d dev_be", i), {28'h0, dev_be}, {28'h0, vecs[i].be});
         chk($sformatf("v%0d dev_wd", i), dev_wd, vecs[i].wd);
         tick();
         idle();
         chk($sformatf("v%0d rvalid", i), {31'h0, pr_rvalid}, {31'h0, vecs[i].re});
         if (vecs[i].re) chk($sformatf("v%0d pr_rd", i), pr_rd, vecs[i].exp_rd);
         chk($sformatf("v%0d bus_err", i), {31'h0, bus_err}, 32'h0);
         tick();
         chk($sformatf("v%0d rvalid drop", i), {31'h0, pr_rvalid}, 32'h0);
      end

      // back-to-back reads
      drive(32'h7f00, 1'b0, 1'b1, 4'h0, 32'h0);
      tick();
      drive(32'h7f14, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("b2b first rvalid", {31'h0, pr_rvalid}, 32'h1);
      chk("b2b first rd", pr_rd, 32'h1234_5678);
      tick();
      idle();
      chk("b2b second rvalid", {31'h0, pr_rvalid}, 32'h1);
      chk("b2b second rd", pr_rd, 32'h0000_a5a5);
      tick();
      chk("b2b rvalid drop", {31'h0, pr_rvalid}, 32'h0);

      // unmapped accesses and ERR clear
      drive(32'h8000, 1'b1, 1'b0, 4'hf, 32'hff);
      #1;
      chk("unmapped dev_we", {30'h0, dev_we}, 32'h0);
      tick();
      idle();
      chk("unmapped wr bus_err", {31'h0, bus_err}, 32'h1);
      access(32'h8000, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("unmapped rd rvalid", {31'h0, pr_rvalid}, 32'h1);
      chk("unmapped rd data", pr_rd, 32'h0);
      access(32'h7f28, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("err reg read", pr_rd, 32'h1);
      access(32'h7f28, 1'b1, 1'b0, 4'hf, 32'h0);
      chk("err clear", {31'h0, bus_err}, 32'h0);
      access(32'h7f2c, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("past ictl bus_err", {31'h0, bus_err}, 32'h1);
      chk("past ictl rd", pr_rd, 32'h0);
      access(32'h7f28, 1'b1, 1'b0, 4'h0, 32'h0);
      chk("err clear be0", {31'h0, bus_err}, 32'h0);

      // edge source dev_irq[0]: 2-cycle latency, sticky, W1C
      dev_irq = 2'b01;
      tick();
      chk("edge latency 1", {26'h0, hwint}, 32'h0);
      dev_irq = 2'b00;
      tick();
      chk("edge latency 2", {26'h0, hwint}, 32'h01);
      repeat (3) tick();
      chk("edge sticky", {26'h0, hwint}, 32'h01);
      access(32'h7f20, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("pending read", pr_rd, 32'h1);
      access(32'h7f20, 1'b1, 1'b0, 4'hf, 32'h1);
      chk("edge w1c", {26'h0, hwint}, 32'h0);
      tick();
      chk("edge stays clear", {26'h0, hwint}, 32'h0);

      // new edge in the same cycle as W1C: set wins
      dev_irq = 2'b01;
      tick();
      access(32'h7f20, 1'b1, 1'b0, 4'hf, 32'h1);
      chk("set beats w1c", {26'h0, hwint}, 32'h01);
      dev_irq = 2'b00;
      access(32'h7f20, 1'b1, 1'b0, 4'hf, 32'h1);
      chk("w1c after set", {26'h0, hwint}, 32'h0);

      // level source dev_irq[1]: W1C ignored, follows source
      dev_irq = 2'b10;
      tick();
      tick();
      chk("level on", {26'h0, hwint}, 32'h02);
      access(32'h7f20, 1'b1, 1'b0, 4'hf, 32'h2);
      chk("level w1c ignored", {26'h0, hwint}, 32'h02);
      dev_irq = 2'b00;
      tick();
      tick();
      chk("level off", {26'h0, hwint}, 32'h0);

      // ext_int level with mask updates
      ext_int = 1'b1;
      tick();
      tick();
      chk("ext on", {26'h0, hwint}, 32'h04);
      access(32'h7f24, 1'b1, 1'b0, 4'hf, 32'h3);
      chk("ext masked", {26'h0, hwint}, 32'h0);
      access(32'h7f24, 1'b1, 1'b0, 4'h0, 32'h7);
      chk("mask be0 ignored", {26'h0, hwint}, 32'h0);
      access(32'h7f24, 1'b1, 1'b0, 4'h1, 32'h7);
      chk("ext unmasked", {26'h0, hwint}, 32'h04);
      access(32'h7f24, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("mask read", pr_rd, 32'h7);
      access(32'h7f24, 1'b1, 1'b0, 4'hf, 32'h1);
      access(32'h9000, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("pre-reset bus_err", {31'h0, bus_err}, 32'h1);

      // reset arriving with a read outstanding
      drive(32'h7f24, 1'b0, 1'b1, 4'h0, 32'h0);
      reset = 1'b1;
      tick();
      idle();
      chk("reset drops rvalid", {31'h0, pr_rvalid}, 32'h0);
      chk("reset clears hwint", {26'h0, hwint}, 32'h0);
      chk("reset clears bus_err", {31'h0, bus_err}, 32'h0);
      chk("reset clears pr_rd", pr_rd, 32'h0);
      reset   = 1'b0;
      ext_int = 1'b0;
      tick();
      access(32'h7f24, 1'b0, 1'b1, 4'h0, 32'h0);
      chk("mask after reset", pr_rd, 32'h7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
